// File: rtl/pwm_capture.sv
// pwm_capture -- APB3 slave measuring the high time and period of a PWM input.
//
// Measures the high time (rise to fall) and the period (rise to rise) of
// pwm_in in PCLK cycles. Software sees the most recent completed
// measurement, a status word with sticky flags, and a level interrupt.
//
// Ports:
//   PCLK, PRESET      clock, asynchronous active-high reset
//   PSEL, PENABLE     APB select / access phase
//   PWRITE, PADDR     APB direction and address ([11:8] block, [3:2] register)
//   PWDATA, PRDATA    APB write data / registered read data
//   PREADY, PSLVERR   constant 1 / constant 0
//   pwm_in            asynchronous PWM input
//   capture_irq       registered level interrupt
//
// Register map (PADDR[3:2]):
//   0 HIGH_WIDTH  RO  high time of the last completed cycle
//   1 PERIOD      RO  rise-to-rise time of the last completed cycle
//   2 STATUS      [0] valid, [1] overrun, [2] timeout (all W1C), [3] input level
//   3 CTRL        RW  [0] enable, [1] irq_en

module pwm_capture #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TIMEOUT  = 2000000,
    parameter logic [3:0]  ADDR_SEL = 4'h2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        pwm_in,
    output logic        capture_irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [32:0]      TO_VAL  = 33'(TIMEOUT);

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       hit;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] reg_idx;
    logic       wr_status;
    logic       wr_ctrl;

    assign hit       = PSEL & (PADDR[11:8] == ADDR_SEL);
    assign wr_en     = hit & PENABLE & PWRITE;
    assign rd_en     = hit & ~PENABLE & ~PWRITE;
    assign reg_idx   = PADDR[3:2];
    assign wr_status = wr_en & (reg_idx == 2'd2);
    assign wr_ctrl   = wr_en & (reg_idx == 2'd3);

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // Address and data bits this block does not decode.
    logic unused_apb_bits;
    assign unused_apb_bits = ^{PADDR[31:12], PADDR[7:4], PADDR[1:0], PWDATA[31:3]};

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic pwm_meta_q;
    logic pwm_s_q;
    logic pwm_d_q;
    logic rise;
    logic fall;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pwm_meta_q <= 1'b0;
            pwm_s_q    <= 1'b0;
            pwm_d_q    <= 1'b0;
        end else begin
            pwm_meta_q <= pwm_in;
            pwm_s_q    <= pwm_meta_q;
            pwm_d_q    <= pwm_s_q;
        end
    end

    assign rise = pwm_s_q & ~pwm_d_q;
    assign fall = ~pwm_s_q & pwm_d_q;

    // ------------------------------------------------------------------
    // Control / status / result registers
    // ------------------------------------------------------------------
    logic             enable_q;
    logic             irq_en_q;
    logic             valid_q;
    logic             overrun_q;
    logic             timeout_q;
    logic [CNT_W-1:0] high_width_q;
    logic [CNT_W-1:0] period_q;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_cnt_d;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_d;
    logic [CNT_W-1:0] hi_shadow_q;
    logic [CNT_W-1:0] hi_shadow_d;
    logic             commit;
    logic             timeout_evt;
    logic             per_at_limit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    // Widened compare so a TIMEOUT beyond the counter range can never match.
    assign per_at_limit = (33'(per_cnt_q) == TO_VAL);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            hi_cnt_q    <= '0;
            per_cnt_q   <= '0;
            hi_shadow_q <= '0;
        end else begin
            state_q     <= state_d;
            hi_cnt_q    <= hi_cnt_d;
            per_cnt_q   <= per_cnt_d;
            hi_shadow_q <= hi_shadow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_cnt_d    = hi_cnt_q;
        per_cnt_d   = per_cnt_q;
        hi_shadow_d = hi_shadow_q;
        commit      = 1'b0;
        timeout_evt = 1'b0;

        if (!enable_q) begin
            // Disabling abandons any measurement in flight without a commit.
            state_d   = ST_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARM;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d   = ST_HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end else begin
                        hi_cnt_d  = '0;
                        per_cnt_d = '0;
                    end
                end
                ST_HIGH: begin
                    // A rise cannot occur here: the input is already high.
                    if (per_at_limit) begin
                        timeout_evt = 1'b1;
                        state_d     = ST_ARM;
                    end else begin
                        hi_cnt_d  = sat_inc(hi_cnt_q);
                        per_cnt_d = sat_inc(per_cnt_q);
                        if (fall) begin
                            hi_shadow_d = hi_cnt_q;
                            state_d     = ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    // Rise has priority over a coincident timeout.
                    if (rise) begin
                        commit    = 1'b1;
                        state_d   = ST_HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end else if (per_at_limit) begin
                        timeout_evt = 1'b1;
                        state_d     = ST_ARM;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register updates; a hardware set beats a coincident W1C.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            high_width_q <= '0;
            period_q     <= '0;
        end else begin
            if (wr_ctrl) begin
                enable_q <= PWDATA[0];
                irq_en_q <= PWDATA[1];
            end
            if (commit) begin
                high_width_q <= hi_shadow_q;
                period_q     <= per_cnt_q;
            end
            valid_q   <= (valid_q   & ~(wr_status & PWDATA[0])) | commit;
            overrun_q <= (overrun_q & ~(wr_status & PWDATA[1])) | (commit & valid_q);
            timeout_q <= (timeout_q & ~(wr_status & PWDATA[2])) | timeout_evt;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            capture_irq <= 1'b0;
        end else begin
            capture_irq <= irq_en_q & (valid_q | timeout_q);
        end
    end

    // ------------------------------------------------------------------
    // Read path: loaded in the setup phase, held through the access phase.
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            2'd0: rd_mux = 32'(high_width_q);
            2'd1: rd_mux = 32'(period_q);
            2'd2: rd_mux = {28'd0, pwm_s_q, timeout_q, overrun_q, valid_q};
            2'd3: rd_mux = {30'd0, irq_en_q, enable_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PRDATA <= '0;
        end else if (rd_en) begin
            PRDATA <= rd_mux;
        end
    end

endmodule
